// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator. An instruction/type/tag enters over a valid/ready handshake.
// The immediate is returned one cycle later. A 2-entry skid buffer keeps in_ready off any combinational path.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } result_t;

  result_t     new_res;
  result_t     main_q, skid_q;
  logic        main_valid, skid_valid;
  logic signed [31:0] imm32;
  logic        in_fire, out_fire;

  // The 32-bit form is built first. Widening it as a signed value gives the XLEN=64 sign extension.
  // The Z and SH forms keep bit 31 clear, so that widening zero-extends them.
  always_comb begin
    imm32       = '0;
    new_res     = '0;
    new_res.tag = in_tag;
    unique case (imm_type_e'(in_imm_type))
      IMM_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      IMM_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      IMM_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      IMM_U:   imm32 = {in_inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      IMM_Z:   imm32 = {27'b0, in_inst[19:15]};
      IMM_SH:  imm32 = {26'b0, (XLEN == 64) ? in_inst[25] : 1'b0, in_inst[24:20]};
      IMM_BAD: new_res.err = 1'b1;
      default: new_res.err = 1'b1;
    endcase
    new_res.imm = XLEN'(imm32);
  end

  // NOTE: in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;

  // NOTE: the payload registers are reset as well as the valid bits, so out_* reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (skid_valid) begin
      // in_ready is low here, so only the drain of the skid entry can happen
      if (out_ready) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid || out_ready) begin
        main_q     <= new_res;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= new_res;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

  assign out_valid = main_valid;
  assign out_imm   = main_q.imm;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;

endmodule
